alu_op_sequencer: RTL

Multi-cycle front end that feeds the 8-bit `alu` datapath stage. It accepts operation requests over a valid/ready handshake and latches the operands. It drives the ALU one byte per cycle, chaining carry from low byte to high byte for 16-bit operations. The result is held in an output register until the consumer takes it. The `alu` is instantiated beside this block in the parent. This block owns only the ALU's input ports and samples its outputs.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_op_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 8-bit alu datapath stage and its front-end
// sequencer.
//   - ALU mode codes, handed to the ALU's aluMode input unchanged
//   - sequencer state encoding (seq_state_t)
//   - byte and word widths plus small byte-select helpers
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_M1  = 4'b0001;
  localparam logic [3:0] ALU_M2  = 4'b0010;
  localparam logic [3:0] ALU_M3  = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  function automatic logic [BYTE_W-1:0] lo_byte(input logic [WORD_W-1:0] w);
    return w[BYTE_W-1:0];
  endfunction

  function automatic logic [BYTE_W-1:0] hi_byte(input logic [WORD_W-1:0] w);
    return w[WORD_W-1:BYTE_W];
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Multi-cycle front end for the external 8-bit alu. It accepts a request,
// latches the operands and runs one ALU pass (narrow) or two passes (wide).
// On a wide op the carry-out of the low pass feeds the carry-in of the high
// pass. It then holds the result until the consumer takes it.
//
// Handshakes (both ports): a transfer happens at a rising clk edge where
// valid and ready are both high. A producer holds valid and payload stable
// until that edge. ready never depends on the same port's valid.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   request handshake
//   req_a, req_b      16-bit operands (upper bytes ignored when narrow)
//   req_ci            carry-in for the low-byte pass
//   req_mode          aluMode code, passed through untouched
//   req_wide          1 = two passes (16-bit), 0 = one pass (8-bit)
//   alu_a/b/ci/mode   drive to the ALU inputs (zero outside LO/HI)
//   alu_s, alu_cout   ALU combinational results, sampled at the clk edge
//   rsp_valid/ready   response handshake
//   rsp_s, rsp_cout   result word and final carry-out
//   dbg_state         current sequencer state, for observation only
// ---------------------------------------------------------------------------
module alu_op_sequencer
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WORD_W-1:0] req_a,
  input  logic [WORD_W-1:0] req_b,
  input  logic              req_ci,
  input  logic [3:0]        req_mode,
  input  logic              req_wide,

  output logic [BYTE_W-1:0] alu_a,
  output logic [BYTE_W-1:0] alu_b,
  output logic              alu_ci,
  output logic [3:0]        alu_mode,
  input  logic [BYTE_W-1:0] alu_s,
  input  logic              alu_cout,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_s,
  output logic              rsp_cout,

  output seq_state_t        dbg_state
);

  seq_state_t        state_q;

  // Operands latched on accept; req_* are ignored afterwards.
  logic [WORD_W-1:0] a_q;
  logic [WORD_W-1:0] b_q;
  logic              ci_q;
  logic [3:0]        mode_q;
  logic              wide_q;

  // Result word and carry. The carry feeds the high pass and then becomes
  // the final carry-out.
  logic [WORD_W-1:0] res_q;
  logic              carry_q;
  logic              rsp_valid_q;

  logic              accept;

  // A held response leaves DONE in the same cycle the consumer takes it, so
  // a new request can be taken in that cycle too.
  assign req_ready = (state_q == ST_IDLE) ||
                     ((state_q == ST_DONE) && rsp_ready);
  assign accept    = req_valid && req_ready;

  // ALU drive is a pure decode of the state and the latched operands. All
  // inputs come from registers, so the ALU sees a stable value for the whole
  // pass, and the drive is zero in IDLE and DONE.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ci   = 1'b0;
    alu_mode = '0;
    case (state_q)
      ST_LO: begin
        alu_a    = lo_byte(a_q);
        alu_b    = lo_byte(b_q);
        alu_ci   = ci_q;
        alu_mode = mode_q;
      end
      ST_HI: begin
        alu_a    = hi_byte(a_q);
        alu_b    = hi_byte(b_q);
        alu_ci   = carry_q;
        alu_mode = mode_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      ci_q        <= 1'b0;
      mode_q      <= '0;
      wide_q      <= 1'b0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;

        ST_LO: begin
          res_q[BYTE_W-1:0] <= alu_s;
          carry_q           <= alu_cout;
          if (wide_q) begin
            state_q <= ST_HI;
          end else begin
            res_q[WORD_W-1:BYTE_W] <= '0;
            rsp_valid_q            <= 1'b1;
            state_q                <= ST_DONE;
          end
        end

        ST_HI: begin
          res_q[WORD_W-1:BYTE_W] <= alu_s;
          carry_q                <= alu_cout;
          rsp_valid_q            <= 1'b1;
          state_q                <= ST_DONE;
        end

        ST_DONE: begin
          // res_q and carry_q are not written here, so the response stays
          // frozen for as long as the consumer stalls.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase

      // Accept has the last word, so it overrides the DONE->IDLE move when a
      // new request arrives in the same cycle as the consumer's ready.
      if (accept) begin
        a_q     <= req_a;
        b_q     <= req_b;
        ci_q    <= req_ci;
        mode_q  <= req_mode;
        wide_q  <= req_wide;
        state_q <= ST_LO;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_s     = res_q;
  assign rsp_cout  = carry_q;
  assign dbg_state = state_q;

endmodule
